// File: rtl/btn_debounce_pkg.sv
// Shared constants for the button conditioner: channel indices and debounce windows.
// SIM_DEBOUNCE_CYCLES keeps simulation windows short; DEBOUNCE_CYCLES is 10 ms at 100 MHz.
package debounce_pkg;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;
  localparam int NUM_BTNS   = 5;

  localparam int DEBOUNCE_CYCLES     = 1_000_000;
  localparam int SIM_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/btn_debounce_if.sv
// Button bus between board inputs and the conditioner: raw levels in, clean levels out.
// Optional per-channel change strobe exists only when BTN_DEBOUNCE_CHG_EN is defined.
interface btn_debounce_if #(
  parameter int N = 5
);
  logic [N-1:0] I;
  logic [N-1:0] Y;
`ifdef BTN_DEBOUNCE_CHG_EN
  logic [N-1:0] chg;

  modport master (output I, input Y, input chg);
  modport slave  (input I, output Y, output chg);
`else
  modport master (output I, input Y);
  modport slave  (input I, output Y);
`endif
endinterface

// File: rtl/btn_debounce_channel.sv
// Single-bit debouncer: 2-flop synchronizer, saturating stability counter, registered level.
// Y follows a new level CNT_MAX+2 edges after it is first sampled; chg (BTN_DEBOUNCE_CHG_EN) marks that cycle.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_MAX = DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
`ifdef BTN_DEBOUNCE_CHG_EN
  output logic o_chg,
`endif
  output logic o_y
);

  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;
  logic          r_y;
  logic          w_diff;
  logic          w_done;

  assign w_diff = r_s2 ^ r_y;
  assign w_done = (r_cnt == CNT_LAST);

  // Any cycle where the synchronized level agrees with Y restarts qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_cnt <= '0;
      r_y   <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_y   <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_y = r_y;

`ifdef BTN_DEBOUNCE_CHG_EN
  logic r_chg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chg <= 1'b0;
    end else begin
      r_chg <= w_diff & w_done;
    end
  end

  assign o_chg = r_chg;
`endif

endmodule

// File: rtl/btn_debounce.sv
// N independent button debouncers; each Y bit is registered, no combinational path from I.
// Optional change strobes per channel are built in when BTN_DEBOUNCE_CHG_EN is defined.
module btn_debounce
  import debounce_pkg::*;
#(
  parameter int N       = NUM_BTNS,
  parameter int CNT_MAX = DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  btn_debounce_if.slave   bus
);

  logic [N-1:0] w_y;
`ifdef BTN_DEBOUNCE_CHG_EN
  logic [N-1:0] w_chg;
`endif

  for (genvar g = 0; g < N; g++) begin : g_ch
    debounce_channel #(
      .CNT_MAX (CNT_MAX)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .i_btn (bus.I[g]),
`ifdef BTN_DEBOUNCE_CHG_EN
      .o_chg (w_chg[g]),
`endif
      .o_y   (w_y[g])
    );
  end

  assign bus.Y = w_y;
`ifdef BTN_DEBOUNCE_CHG_EN
  assign bus.chg = w_chg;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with a short window: stimulus queues expected Y changes and the
// cycle they must land on; a monitor pops one entry per observed Y change.
module tb_btn_debounce;
  import debounce_pkg::*;

  localparam int N   = 5;
  localparam int CM  = SIM_DEBOUNCE_CYCLES;
  localparam int LAT = CM + 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  btn_debounce_if #(.N(N)) bus ();

  btn_debounce #(
    .N       (N),
    .CNT_MAX (CM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] y;
    int           cyc;
  } ev_t;

  ev_t          q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [N-1:0] prev_y  = '0;

  // Called at a negedge when I changes: the next rising edge is edge 1.
  task automatic expect_y(input logic [N-1:0] y);
    ev_t e;
    e.y   = y;
    e.cyc = cyc + LAT;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor samples 3 ns after each rising edge.
  always @(posedge clk) begin : monitor
    ev_t e;
    #3;
    if (rst) begin
      n_tests++;
      if (bus.Y !== '0) begin
        n_fail++;
        $display("FAIL reset_y: got %b, want %b", bus.Y, {N{1'b0}});
      end
`ifdef BTN_DEBOUNCE_CHG_EN
      n_tests++;
      if (bus.chg !== '0) begin
        n_fail++;
        $display("FAIL reset_chg: got %b, want %b", bus.chg, {N{1'b0}});
      end
`endif
      prev_y = '0;
    end else begin
`ifdef BTN_DEBOUNCE_CHG_EN
      n_tests++;
      if (bus.chg !== (bus.Y ^ prev_y)) begin
        n_fail++;
        $display("FAIL chg_strobe @cyc %0d: got %b, want %b", cyc, bus.chg, bus.Y ^ prev_y);
      end
`endif
      if (bus.Y !== prev_y) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_y @cyc %0d: got %b, want %b (no change expected)",
                   cyc, bus.Y, prev_y);
        end else begin
          e = q.pop_front();
          if (bus.Y !== e.y || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL y_event: got %b @cyc %0d, want %b @cyc %0d", bus.Y, cyc, e.y, e.cyc);
          end
        end
        prev_y = bus.Y;
      end
    end
  end

  initial begin
    rst   = 1'b1;
    bus.I = '1;
    tick(3);

    // Reset release with all buttons already held
    rst = 1'b0;
    expect_y(5'b11111);
    tick(12);
    bus.I = '0;
    expect_y(5'b00000);
    tick(12);

    // Clean press and release on channel 0
    bus.I[BTN_UP] = 1'b1;
    expect_y(5'b00001);
    tick(12);
    bus.I[BTN_UP] = 1'b0;
    expect_y(5'b00000);
    tick(12);

    // CNT_MAX-1 cycle glitch is rejected
    bus.I[BTN_LEFT] = 1'b1;
    tick(CM - 1);
    bus.I[BTN_LEFT] = 1'b0;
    tick(12);

    // CNT_MAX cycle pulse is accepted and lasts CNT_MAX cycles at Y
    bus.I[BTN_LEFT] = 1'b1;
    expect_y(5'b00100);
    tick(CM);
    bus.I[BTN_LEFT] = 1'b0;
    expect_y(5'b00000);
    tick(12);

    // Bounce train of 2-cycle pulses, then a stable high
    for (int k = 0; k < 20; k++) begin
      bus.I[BTN_DOWN] = ~bus.I[BTN_DOWN];
      tick(2);
    end
    bus.I[BTN_DOWN] = 1'b1;
    expect_y(5'b00010);
    tick(12);
    bus.I[BTN_DOWN] = 1'b0;
    expect_y(5'b00000);
    tick(12);

    // Simultaneous press on channels 3 and 4, then independent releases
    bus.I[BTN_CENTER:BTN_RIGHT] = 2'b11;
    expect_y(5'b11000);
    tick(12);
    bus.I[BTN_RIGHT] = 1'b0;
    expect_y(5'b10000);
    tick(12);
    bus.I[BTN_CENTER] = 1'b0;
    expect_y(5'b00000);
    tick(12);

    // Reset while channel 0 has counted to 2; full window restarts from release
    bus.I[BTN_UP] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    expect_y(5'b00001);
    tick(12);
    bus.I[BTN_UP] = 1'b0;
    expect_y(5'b00000);
    tick(12);

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d outstanding, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Multi-channel push-button conditioner that sits directly upstream of the edge pulsers in the input path. Each raw board button is synchronized into `clk` and debounced with a saturating stability counter. The block emits a clean, glitch-free level per channel that the pulsers turn into one-cycle move/select strobes. All channels are identical and fully independent.

## Interface
- `N`, 5, number of button channels (up, down, left, right, centre).
- `CNT_MAX`, 1_000_000, consecutive stable cycles required before the output follows the input (10 ms at 100 MHz); legal range ≥ 2.
- `clk`  input  1  system clock, all state on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `I`  input  N  raw asynchronous button levels, bit i = channel i.
- `Y`  output  N  debounced level per channel, registered.
- `chg`  output  N  one-cycle change strobe per channel; present only with `BTN_DEBOUNCE_CHG_EN`.

## Operation
- Per channel, stage 1 is a 2-flop synchronizer: `s1 <= I[i]`, `s2 <= s1`.
- Per channel, stage 2 is a counter `cnt`, width `CW = $clog2(CNT_MAX)`, plus the stable level `Y[i]`.
- `s2 == Y[i]`: `cnt <= 0`, `Y[i]` holds.
- `s2 != Y[i]` and `cnt != CNT_MAX-1`: `cnt <= cnt + 1`.
- `s2 != Y[i]` and `cnt == CNT_MAX-1`: `Y[i] <= s2`, `cnt <= 0`.
- `cnt` never exceeds `CNT_MAX-1`. No wrap-around is possible.
- Any single cycle where `s2` matches `Y[i]` restarts qualification from 0. This rejects bounce trains of arbitrary length.
- Rises and falls use the same rule. The behaviour is symmetric.
- Channels do not interact. Simultaneous presses are debounced independently and may resolve on the same edge.

## Timing
- Reset values: `s1`, `s2`, `cnt`, `Y`, `chg` are all 0. Outputs read "not pressed" immediately after reset.
- Reset asserted mid-qualification discards the partial count. After release, the input must again be stable for the full window.
- Latency: take rising edge 1 as the first edge that samples a new stable `I[i]`. `Y[i]` changes after edge `CNT_MAX+2`.
- Minimum accepted pulse: the level must be present at `s2` for `CNT_MAX` consecutive cycles. A pulse of `CNT_MAX-1` cycles is fully rejected, and `Y` does not move.
- `Y` toggles at most once per `CNT_MAX` cycles per channel.
- Output is registered. There is no combinational path from `I` to `Y`.

## Configuration
- `BTN_DEBOUNCE_CHG_EN` defined:
  - port `chg[N-1:0]` exists.
  - `chg[i]` is registered and high for exactly one cycle. That cycle is the first cycle in which `Y[i]` shows its new value, for both rise and fall.
  - `chg[i]` resets to 0.
- Macro undefined: the `chg` port and its flops are absent. `Y` behaviour is identical.

## Structure
- Package `debounce_pkg`:
  - `BTN_UP`, `BTN_DOWN`, `BTN_LEFT`, `BTN_RIGHT`, `BTN_CENTER` channel index constants.
  - default `DEBOUNCE_CYCLES` = 1_000_000.
  - `SIM_DEBOUNCE_CYCLES` = 4, for benches.
- Sub-module `debounce_channel`, single bit: synchronizer, counter, `Y` and optional `chg`.
  - `btn_debounce` instantiates it `N` times in a generate loop.

## Test plan
- Reset: with `CNT_MAX=4`, `I=5'b11111` held during reset → `Y=0` and `chg=0` while `rst=1`; `Y=5'b11111` after edge 6 following release.
- Clean press: `CNT_MAX=4`, `I[0]` 0→1 and held → `Y[0]` rises after edge 6. With the macro, `chg[0]=1` for that one cycle only.
- Glitch rejection: `CNT_MAX=4`, `I[2]` high for 3 cycles then low → `Y[2]` stays 0 throughout. The same test with 4 high cycles → `Y[2]` pulses high for at least 4 cycles.
- Bounce train: `I[1]` toggles every 2 cycles for 40 cycles, then holds high → `Y[1]` rises exactly `CNT_MAX+2` edges after the final toggle, with no earlier transition.
- Release and simultaneity: `I[3]` and `I[4]` rise on the same cycle → both `Y` bits rise on the same edge. A later fall of `I[3]` only → `Y[3]` falls after `CNT_MAX+2` edges and `Y[4]` is unchanged.
- Mid-operation reset: `rst` pulsed while `cnt=2` on a rising `I[0]` → `Y[0]` stays 0. The full `CNT_MAX+2` latency is re-measured from release.
